// File: rtl/mode4_exp_accum.sv
// mode4_exp_accum
//   Consumer side of the 8-lane exp stage. Each accepted beat carries eight
//   fp exp results; they are reduced through a registered 3-level fp adder
//   tree (S1: four pair sums, S2: two sums, S3: one sum) and accumulated
//   until the beat flagged in_last. The completed sum (softmax denominator)
//   and its beat count are presented on a registered output.
//
//   Handshake semantics (both sides): a transfer happens on a rising edge
//   where valid && ready are both 1. Once out_valid is raised, sum_out and
//   beat_count hold until the transfer. The whole pipeline advances only
//   when the output register can take a new result (adv); in_ready = adv,
//   so a stalled output freezes every stage and no beat is lost or repeated.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   inp0..inp7            fp exp results of one beat
//   in_valid/in_ready     input beat handshake, in_last marks final beat
//   sum_out, beat_count   completed vector sum and its beat count (saturating)
//   out_valid/out_ready   output handshake
module mode4_exp_accum #(
    parameter int DATAWIDTH       = 16,
    parameter int MANTISSA        = 10,
    parameter int EXPONENT        = 5,
    parameter int IEEE_COMPLIANCE = 0,
    parameter int CNTW            = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATAWIDTH-1:0] inp0,
    input  logic [DATAWIDTH-1:0] inp1,
    input  logic [DATAWIDTH-1:0] inp2,
    input  logic [DATAWIDTH-1:0] inp3,
    input  logic [DATAWIDTH-1:0] inp4,
    input  logic [DATAWIDTH-1:0] inp5,
    input  logic [DATAWIDTH-1:0] inp6,
    input  logic [DATAWIDTH-1:0] inp7,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [DATAWIDTH-1:0] sum_out,
    output logic [CNTW-1:0]      beat_count,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int M  = MANTISSA;
    localparam int E  = EXPONENT;
    localparam int GW = M + 4;                 // hidden bit + fraction + guard/round/sticky
    localparam logic [E-1:0] EMAX = '1;

    // Combinational fp add with DW_fp_add behaviour: round-to-nearest-even,
    // subnormal inputs/results flushed to zero, inf propagates. inf + -inf
    // yields a NaN pattern in IEEE mode, +inf otherwise. No status flags.
    function automatic logic [DATAWIDTH-1:0] fp_add(input logic [DATAWIDTH-1:0] a,
                                                    input logic [DATAWIDTH-1:0] b);
        logic                 sa, sb, sl, ss, lost, rup;
        logic [E-1:0]         ea, eb, el, es, d;
        logic [GW-1:0]        ml, ms, mask, norm;
        logic [GW:0]          sum;
        logic [M+1:0]         mant;
        logic [DATAWIDTH-1:0] z;
        int                   ex;
        sa = a[DATAWIDTH-1];
        sb = b[DATAWIDTH-1];
        ea = a[M+E-1:M];
        eb = b[M+E-1:M];
        // Order operands by magnitude so the aligned difference is never negative.
        if ({ea, a[M-1:0]} >= {eb, b[M-1:0]}) begin
            sl = sa; el = ea; ml = {1'b1, a[M-1:0], 3'b000};
            ss = sb; es = eb; ms = {1'b1, b[M-1:0], 3'b000};
        end else begin
            sl = sb; el = eb; ml = {1'b1, b[M-1:0], 3'b000};
            ss = sa; es = ea; ms = {1'b1, a[M-1:0], 3'b000};
        end
        d    = el - es;
        mask = (int'(d) >= GW) ? '1 : ((GW'(1) << d) - GW'(1));
        lost = |(ms & mask);
        ms   = (int'(d) >= GW) ? '0 : (ms >> d);
        ms[0] = ms[0] | lost;                  // bits shifted out fold into sticky
        sum  = (sl == ss) ? ({1'b0, ml} + {1'b0, ms}) : ({1'b0, ml} - {1'b0, ms});
        ex   = int'(el);
        if (sum[GW]) begin
            norm    = sum[GW:1];
            norm[0] = norm[0] | sum[0];
            ex      = ex + 1;
        end else begin
            norm = sum[GW-1:0];
            for (int i = 0; i < GW; i++) begin
                if (!norm[GW-1] && norm != '0) begin
                    norm = norm << 1;
                    ex   = ex - 1;
                end
            end
        end
        rup  = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant = {1'b0, norm[GW-1:3]} + {{(M+1){1'b0}}, rup};
        if (mant[M+1]) begin
            mant = mant >> 1;
            ex   = ex + 1;
        end
        if (ea == EMAX || eb == EMAX) begin
            if (ea == EMAX && eb == EMAX && sa != sb)
                z = {1'b0, EMAX, (IEEE_COMPLIANCE != 0), {(M-1){1'b0}}};
            else
                z = {(ea == EMAX) ? sa : sb, EMAX, {M{1'b0}}};
        end else if (ea == '0 && eb == '0) begin
            z = {sa & sb, {(DATAWIDTH-1){1'b0}}};
        end else if (ea == '0) begin
            z = b;
        end else if (eb == '0) begin
            z = a;
        end else if (sum == '0) begin
            z = '0;
        end else if (ex >= int'(EMAX)) begin
            z = {sl, EMAX, {M{1'b0}}};
        end else if (ex <= 0 || !mant[M]) begin
            z = {sl, {(DATAWIDTH-1){1'b0}}};
        end else begin
            z = {sl, E'(ex), mant[M-1:0]};
        end
        return z;
    endfunction

    logic                 adv;
    logic [DATAWIDTH-1:0] lane [8];
    logic [DATAWIDTH-1:0] p1 [4];
    logic [DATAWIDTH-1:0] s1 [4];
    logic [DATAWIDTH-1:0] p2 [2];
    logic [DATAWIDTH-1:0] s2 [2];
    logic [DATAWIDTH-1:0] p3, s3, acc, acc_new;
    logic                 v1, l1, v2, l2, v3, l3, acc_empty;
    logic [CNTW-1:0]      cnt, cnt_new;

    assign lane[0] = inp0;
    assign lane[1] = inp1;
    assign lane[2] = inp2;
    assign lane[3] = inp3;
    assign lane[4] = inp4;
    assign lane[5] = inp5;
    assign lane[6] = inp6;
    assign lane[7] = inp7;

    // The pipeline may move unless a result is pending and not being taken.
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            p1[i] = fp_add(lane[2*i], lane[2*i+1]);
        end
        p2[0]   = fp_add(s1[0], s1[1]);
        p2[1]   = fp_add(s1[2], s1[3]);
        p3      = fp_add(s2[0], s2[1]);
        // First beat of a vector seeds the accumulator directly.
        acc_new = acc_empty ? s3 : fp_add(acc, s3);
        cnt_new = acc_empty ? CNTW'(1) : ((cnt == '1) ? cnt : cnt + CNTW'(1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) s1[i] <= '0;
            s2[0]      <= '0;
            s2[1]      <= '0;
            s3         <= '0;
            v1         <= 1'b0;
            l1         <= 1'b0;
            v2         <= 1'b0;
            l2         <= 1'b0;
            v3         <= 1'b0;
            l3         <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            acc_empty  <= 1'b1;
            sum_out    <= '0;
            beat_count <= '0;
            out_valid  <= 1'b0;
        end else if (adv) begin
            s1 <= p1;
            v1 <= in_valid;                    // in_ready is 1 whenever adv is 1
            l1 <= in_last && in_valid;         // a stray in_last is dropped here
            s2 <= p2;
            v2 <= v1;
            l2 <= l1;
            s3 <= p3;
            v3 <= v2;
            l3 <= l2;
            if (v3 && !l3) begin
                acc       <= acc_new;
                cnt       <= cnt_new;
                acc_empty <= 1'b0;
            end
            if (v3 && l3) begin
                sum_out    <= acc_new;
                beat_count <= cnt_new;
                out_valid  <= 1'b1;
                acc        <= '0;
                cnt        <= '0;
                acc_empty  <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mode4_exp_accum.sv
// Self-checking bench for mode4_exp_accum. Inputs are driven 2 time units
// after each rising edge; outputs are sampled on the falling edge. The
// reference model computes fp16 sums with real arithmetic and an explicit
// round-to-nearest-even conversion, following the tree order of the block.
module tb_mode4_exp_accum;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [15:0] lanes [8];
    logic        in_valid, in_last, out_ready;
    logic        in_ready, out_valid;
    logic [15:0] sum_out;
    logic [7:0]  beat_count;

    logic        in_valid2, in_last2, out_ready2;
    logic        in_ready2, out_valid2;
    logic [15:0] sum_out2;
    logic [1:0]  beat_count2;

    mode4_exp_accum dut (
        .clk(clk), .reset(reset),
        .inp0(lanes[0]), .inp1(lanes[1]), .inp2(lanes[2]), .inp3(lanes[3]),
        .inp4(lanes[4]), .inp5(lanes[5]), .inp6(lanes[6]), .inp7(lanes[7]),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .sum_out(sum_out), .beat_count(beat_count),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    mode4_exp_accum #(.CNTW(2)) dut2 (
        .clk(clk), .reset(reset),
        .inp0(lanes[0]), .inp1(lanes[1]), .inp2(lanes[2]), .inp3(lanes[3]),
        .inp4(lanes[4]), .inp5(lanes[5]), .inp6(lanes[6]), .inp7(lanes[7]),
        .in_valid(in_valid2), .in_last(in_last2), .in_ready(in_ready2),
        .sum_out(sum_out2), .beat_count(beat_count2),
        .out_valid(out_valid2), .out_ready(out_ready2)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;

    always @(posedge clk) cycle <= cycle + 1;

    // ---------------- scoreboard ----------------
    logic [23:0] exp_q [$];
    logic [23:0] obs_q [$];
    int          obs_t [$];

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            obs_q.push_back({sum_out, beat_count});
            obs_t.push_back(cycle);
        end
    end

    // ---------------- reference model ----------------
    function automatic real h2r(input logic [15:0] h);
        int  e;
        real m;
        e = int'(h[14:10]);
        if (e == 0) return 0.0;
        m = 1.0 + real'(h[9:0]) / 1024.0;
        return (h[15] ? -m : m) * (2.0 ** (e - 15));
    endfunction

    function automatic logic [15:0] r2h(input real r);
        logic [63:0] b;
        logic [52:0] m;
        logic [11:0] m11;
        int          e;
        if (r == 0.0) return 16'h0000;
        b   = $realtobits(r);
        e   = int'(b[62:52]) - 1023;
        m   = {1'b1, b[51:0]};
        m11 = {1'b0, m[52:42]};
        if (m[41] && ((|m[40:0]) || m11[0])) m11 = m11 + 12'd1;
        if (m11[11]) begin
            m11 = m11 >> 1;
            e   = e + 1;
        end
        if (e > 15) return {b[63], 5'h1f, 10'h000};
        if (e < -14) return {b[63], 15'h0000};
        return {b[63], 5'(e + 15), m11[9:0]};
    endfunction

    function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
        return r2h(h2r(a) + h2r(b));
    endfunction

    function automatic logic [15:0] tree_sum();
        logic [15:0] lo, hi;
        lo = fadd(fadd(lanes[0], lanes[1]), fadd(lanes[2], lanes[3]));
        hi = fadd(fadd(lanes[4], lanes[5]), fadd(lanes[6], lanes[7]));
        return fadd(lo, hi);
    endfunction

    function automatic logic [15:0] rand_lane();
        if ($urandom_range(0, 9) == 0) return 16'h0000;
        return {1'b0, 5'($urandom_range(10, 16)), 10'($urandom_range(0, 1023))};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_lanes(input logic [15:0] v);
        for (int i = 0; i < 8; i++) lanes[i] = v;
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < 8; i++) lanes[i] = rand_lane();
    endtask

    // Called in the drive slot; returns in the drive slot after acceptance.
    task automatic drive_beat(input logic last, output int stalls);
        int guard;
        in_valid = 1'b1;
        in_last  = last;
        stalls   = 0;
        guard    = 0;
        @(negedge clk);
        while (!in_ready && guard < 300) begin
            @(posedge clk); #2;
            @(negedge clk);
            stalls++;
            guard++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL beat_accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, guard);
        end
        @(posedge clk); #2;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_obs(input int n, output bit ok);
        int guard;
        guard = 0;
        while (obs_q.size() < n && guard < 600) begin
            @(posedge clk); #2;
            guard++;
        end
        ok = (obs_q.size() >= n);
    endtask

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
        obs_t.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready); else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid); else n_pass++;
        n_checks++;
        if (sum_out !== 16'h0000) $display("FAIL reset_sum_out: got %h want 0000", sum_out); else n_pass++;
        n_checks++;
        if (beat_count !== 8'd0) $display("FAIL reset_beat_count: got %0d want 0", beat_count); else n_pass++;
        @(posedge clk); #2;
    endtask

    task automatic test_single_beat();
        int st, edges;
        clear_sb();
        set_lanes(16'h3C00);
        drive_beat(1'b1, st);
        idle_inputs();
        edges = 1;
        forever begin
            @(negedge clk);
            if (out_valid || edges >= 20) break;
            @(posedge clk); #2;
            edges++;
        end
        n_checks++;
        if (edges !== 4) $display("FAIL single_latency: got %0d edges want 4", edges); else n_pass++;
        n_checks++;
        if (sum_out !== 16'h4800) $display("FAIL single_sum: got %h want 4800", sum_out); else n_pass++;
        n_checks++;
        if (beat_count !== 8'd1) $display("FAIL single_count: got %0d want 1", beat_count); else n_pass++;
        @(posedge clk); #2;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL single_valid_drop: got %0b want 0", out_valid); else n_pass++;
        @(posedge clk); #2;
    endtask

    task automatic test_two_beat();
        int st0, st1;
        bit ok;
        clear_sb();
        set_lanes(16'h3C00);
        drive_beat(1'b0, st0);
        // in_last without in_valid must not end the vector
        in_valid = 1'b0;
        in_last  = 1'b1;
        @(posedge clk); #2;
        set_lanes(16'h3800);
        drive_beat(1'b1, st1);
        idle_inputs();
        wait_obs(1, ok);
        n_checks++;
        if (!ok) $display("FAIL two_beat_timeout: got %0d results want 1", obs_q.size()); else n_pass++;
        n_checks++;
        if ((obs_q.size() > 0 ? obs_q[0] : 24'hxxxxxx) !== {16'h4A00, 8'd2})
            $display("FAIL two_beat_result: got %h want 4a0002", obs_q.size() > 0 ? obs_q[0] : 24'hxxxxxx);
        else n_pass++;
        n_checks++;
        if (st0 + st1 !== 0) $display("FAIL two_beat_in_ready: got %0d stall cycles want 0", st0 + st1); else n_pass++;
        repeat (3) begin @(posedge clk); #2; end
        n_checks++;
        if (obs_q.size() !== 1) $display("FAIL two_beat_extra: got %0d results want 1", obs_q.size()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int st;
        bit ok;
        clear_sb();
        set_lanes(16'h3C00);
        drive_beat(1'b1, st);
        set_lanes(16'h4000);
        drive_beat(1'b1, st);
        idle_inputs();
        wait_obs(2, ok);
        n_checks++;
        if (!ok) $display("FAIL b2b_timeout: got %0d results want 2", obs_q.size()); else n_pass++;
        n_checks++;
        if ((obs_q.size() > 0 ? obs_q[0] : 24'hxxxxxx) !== {16'h4800, 8'd1})
            $display("FAIL b2b_first: got %h want 480001", obs_q.size() > 0 ? obs_q[0] : 24'hxxxxxx);
        else n_pass++;
        n_checks++;
        if ((obs_q.size() > 1 ? obs_q[1] : 24'hxxxxxx) !== {16'h4C00, 8'd1})
            $display("FAIL b2b_second: got %h want 4c0001", obs_q.size() > 1 ? obs_q[1] : 24'hxxxxxx);
        else n_pass++;
        n_checks++;
        if ((obs_t.size() > 1 ? obs_t[1] - obs_t[0] : -1) !== 1)
            $display("FAIL b2b_spacing: got %0d cycles want 1", obs_t.size() > 1 ? obs_t[1] - obs_t[0] : -1);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int          st, guard;
        bit          ok;
        logic [15:0] acc;
        clear_sb();
        out_ready = 1'b0;
        set_lanes(16'h3C00);
        drive_beat(1'b1, st);
        exp_q.push_back({16'h4800, 8'd1});
        set_lanes(16'h4000);
        drive_beat(1'b1, st);
        exp_q.push_back({16'h4C00, 8'd1});
        rand_lanes();
        acc = tree_sum();
        drive_beat(1'b0, st);
        rand_lanes();
        acc = fadd(acc, tree_sum());
        drive_beat(1'b1, st);
        exp_q.push_back({acc, 8'd2});
        idle_inputs();
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (in_ready !== 1'b0) $display("FAIL stall_in_ready: cycle %0d got %0b want 0", c, in_ready); else n_pass++;
            n_checks++;
            if (sum_out !== 16'h4800 || out_valid !== 1'b1)
                $display("FAIL stall_hold: cycle %0d got sum %h valid %0b want 4800 valid 1", c, sum_out, out_valid);
            else n_pass++;
            @(negedge clk);
        end
        @(posedge clk); #2;
        out_ready = 1'b1;
        wait_obs(3, ok);
        repeat (4) begin @(posedge clk); #2; end
        n_checks++;
        if (obs_q.size() !== 3) $display("FAIL stall_count: got %0d results want 3", obs_q.size()); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ((obs_q.size() > i ? obs_q[i] : 24'hxxxxxx) !== exp_q[i])
                $display("FAIL stall_result[%0d]: got %h want %h", i, obs_q.size() > i ? obs_q[i] : 24'hxxxxxx, exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        bit done, ok;
        clear_sb();
        done = 1'b0;
        fork
            begin
                int          st, nb;
                logic [15:0] acc;
                for (int v = 0; v < 25; v++) begin
                    nb = $urandom_range(1, 6);
                    for (int b = 0; b < nb; b++) begin
                        rand_lanes();
                        acc = (b == 0) ? tree_sum() : fadd(acc, tree_sum());
                        drive_beat(b == nb - 1, st);
                        if ($urandom_range(0, 3) == 0) begin
                            idle_inputs();
                            @(posedge clk); #2;
                        end
                    end
                    exp_q.push_back({acc, 8'(nb)});
                end
                idle_inputs();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #2;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_obs(exp_q.size(), ok);
        repeat (4) begin @(posedge clk); #2; end
        n_checks++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL random_count: got %0d results want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if ((obs_q.size() > i ? obs_q[i] : 24'hxxxxxx) !== exp_q[i])
                $display("FAIL random_result[%0d]: got %h want %h", i, obs_q.size() > i ? obs_q[i] : 24'hxxxxxx, exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int st, guard;
        bit ok;
        clear_sb();
        out_ready = 1'b1;
        set_lanes(16'h3C00);
        for (int b = 0; b < 3; b++) drive_beat(1'b0, st);
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        set_lanes(16'h3800);
        drive_beat(1'b1, st);
        idle_inputs();
        wait_obs(1, ok);
        n_checks++;
        if ((obs_q.size() > 0 ? obs_q[0] : 24'hxxxxxx) !== {16'h4400, 8'd1})
            $display("FAIL reset_mid_result: got %h want 440001", obs_q.size() > 0 ? obs_q[0] : 24'hxxxxxx);
        else n_pass++;
        // Reset while a result is stalled discards it.
        clear_sb();
        out_ready = 1'b0;
        set_lanes(16'h4000);
        drive_beat(1'b1, st);
        idle_inputs();
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk); #2;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_stall_clear: got valid %0b ready %0b want 0 1", out_valid, in_ready);
        else n_pass++;
        @(posedge clk); #2;
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (8) begin @(posedge clk); #2; end
        n_checks++;
        if (obs_q.size() !== 0) $display("FAIL reset_stall_residue: got %0d results want 0", obs_q.size()); else n_pass++;
    endtask

    task automatic test_inf();
        int st;
        bit ok;
        clear_sb();
        set_lanes(16'h3C00);
        lanes[0] = 16'h7C00;
        drive_beat(1'b1, st);
        idle_inputs();
        wait_obs(1, ok);
        n_checks++;
        if ((obs_q.size() > 0 ? obs_q[0] : 24'hxxxxxx) !== {16'h7C00, 8'd1})
            $display("FAIL inf_result: got %h want 7c0001", obs_q.size() > 0 ? obs_q[0] : 24'hxxxxxx);
        else n_pass++;
    endtask

    task automatic test_saturation();
        int guard;
        set_lanes(16'h0000);
        out_ready2 = 1'b1;
        for (int b = 0; b < 5; b++) begin
            in_valid2 = 1'b1;
            in_last2  = (b == 4);
            @(posedge clk); #2;
        end
        in_valid2 = 1'b0;
        in_last2  = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!out_valid2 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (out_valid2 !== 1'b1) $display("FAIL sat_valid: got %0b want 1", out_valid2); else n_pass++;
        n_checks++;
        if (beat_count2 !== 2'd3) $display("FAIL sat_count: got %0d want 3", beat_count2); else n_pass++;
        n_checks++;
        if (sum_out2 !== 16'h0000) $display("FAIL sat_sum: got %h want 0000", sum_out2); else n_pass++;
        @(posedge clk); #2;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        out_ready  = 1'b1;
        in_valid2  = 1'b0;
        in_last2   = 1'b0;
        out_ready2 = 1'b1;
        set_lanes(16'h0000);
        test_reset();
        test_single_beat();
        test_two_beat();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_inf();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
